// File: rtl/ptp_chan_delay_line_pkg.sv
`default_nettype none
// ptp_chan_delay_line_pkg: shared idle patterns and injection mask for the PTPv2 channel model.
package ptp_chan_delay_line_pkg;

    localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
    localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;
    localparam logic [7:0]  GMII_IDLE_D  = 8'h00;
    localparam logic [1:0]  GMII_IDLE_C  = 2'b00;
    localparam logic [63:0] DEF_ERR_MASK = 64'h1;

endpackage
`default_nettype wire

// File: rtl/ptp_chan_dly_ram.sv
`default_nettype none
// ptp_chan_dly_ram: simple dual-port delay buffer, synchronous write, asynchronous read.
module ptp_chan_dly_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 72,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/ptp_chan_delay_line.sv
`default_nettype none
// ptp_chan_delay_line: per-direction XGMII/GMII link pipe with run-time delay, frame-safe
// delay changes, single-word error injection and an output frame counter.
module ptp_chan_delay_line
    import ptp_chan_delay_line_pkg::*;
#(
    parameter int                 DATA_W   = 64,
    parameter int                 CTRL_W   = 8,
    parameter int                 MAX_DLY  = 64,
    parameter int                 DEF_DLY  = 8,
    parameter logic [DATA_W-1:0]  IDLE_D   = XGMII_IDLE_D[DATA_W-1:0],
    parameter logic [CTRL_W-1:0]  IDLE_C   = XGMII_IDLE_C[CTRL_W-1:0],
    parameter logic [DATA_W-1:0]  ERR_MASK = DEF_ERR_MASK[DATA_W-1:0],
    parameter int                 AW       = $clog2(MAX_DLY)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_d,
    input  logic [CTRL_W-1:0] in_c,
    output logic [DATA_W-1:0] out_d,
    output logic [CTRL_W-1:0] out_c,
    input  logic [AW:0]       dly_cfg,
    output logic [AW-1:0]     dly_act,
    output logic              dly_pend,
    output logic              dly_clamp,
    input  logic              err_inj,
    output logic              err_done,
    output logic [31:0]       frame_cnt
);

    localparam int            WW      = DATA_W + CTRL_W;
    localparam logic [AW:0]   MAX_CFG = (AW+1)'(MAX_DLY - 1);
    localparam logic [WW-1:0] IDLE_W  = {IDLE_D, IDLE_C};

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     dly_act_q, dly_act_d;
    logic [AW:0]       fill_q, fill_d;
    logic [AW:0]       in_flight_q, in_flight_d;
    logic              arm_q, arm_d;
    logic              clamp_q, clamp_d;
    logic [DATA_W-1:0] out_d_q, out_d_d;
    logic [CTRL_W-1:0] out_c_q, out_c_d;
    logic [31:0]       frame_cnt_q, frame_cnt_d;

    logic              w_in_idle;
    logic              w_corrupt;
    logic [WW-1:0]     w_wr_word;
    logic [AW-1:0]     w_rd_addr;
    logic [WW-1:0]     w_ram_word;
    logic [WW-1:0]     w_out_word;
    logic              w_out_nonidle;
    logic              w_wr_nonidle;
    logic [AW-1:0]     w_target;
    logic              w_apply;
    logic [AW:0]       w_fill_dec;
    logic [AW:0]       w_fill_up;

    assign w_in_idle = ({in_d, in_c} == IDLE_W);
    assign w_corrupt = (arm_q | err_inj) & ~w_in_idle;
    assign w_wr_word = {(w_corrupt ? (in_d ^ ERR_MASK) : in_d), in_c};
    assign w_rd_addr = wr_ptr_q - dly_act_q;
    assign w_target  = (dly_cfg > MAX_CFG) ? MAX_CFG[AW-1:0] : dly_cfg[AW-1:0];

    ptp_chan_dly_ram #(
        .DEPTH (MAX_DLY),
        .WIDTH (WW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_addr (wr_ptr_q),
        .wr_data (w_wr_word),
        .rd_addr (w_rd_addr),
        .rd_data (w_ram_word)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(1);
        dly_act_d   = dly_act_q;
        arm_d       = arm_q;
        clamp_d     = clamp_q | (dly_cfg > MAX_CFG);
        fill_d      = fill_q;
        w_fill_dec  = fill_q - (AW+1)'(fill_q != '0);
        w_fill_up   = w_fill_dec + {1'b0, w_target};
        w_out_word  = IDLE_W;

        // Zero delay reads the word being written this cycle, which the RAM cannot return yet.
        if (fill_q == '0) begin
            w_out_word = (dly_act_q == '0) ? w_wr_word : w_ram_word;
        end
        w_out_nonidle = (w_out_word != IDLE_W);
        w_wr_nonidle  = (w_wr_word != IDLE_W);

        in_flight_d = in_flight_q + (AW+1)'(w_wr_nonidle) - (AW+1)'(w_out_nonidle);

        // Only switch once the pipe holds no frame data and no frame is arriving.
        w_apply = (w_target != dly_act_q) && (in_flight_q == '0) && w_in_idle;
        fill_d  = w_fill_dec;
        if (w_apply) begin
            dly_act_d = w_target;
            fill_d    = (w_fill_up >= {1'b0, dly_act_q}) ? (w_fill_up - {1'b0, dly_act_q}) : '0;
        end

        if (w_corrupt) begin
            arm_d = 1'b0;
        end else if (err_inj) begin
            arm_d = 1'b1;
        end

        out_d_d     = w_out_word[WW-1:CTRL_W];
        out_c_d     = w_out_word[CTRL_W-1:0];
        frame_cnt_d = frame_cnt_q + 32'(w_out_nonidle && ({out_d_q, out_c_q} == IDLE_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            dly_act_q   <= AW'(DEF_DLY);
            fill_q      <= (AW+1)'(DEF_DLY);
            in_flight_q <= '0;
            arm_q       <= 1'b0;
            clamp_q     <= 1'b0;
            out_d_q     <= IDLE_D;
            out_c_q     <= IDLE_C;
            frame_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            dly_act_q   <= dly_act_d;
            fill_q      <= fill_d;
            in_flight_q <= in_flight_d;
            arm_q       <= arm_d;
            clamp_q     <= clamp_d;
            out_d_q     <= out_d_d;
            out_c_q     <= out_c_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_d     = out_d_q;
    assign out_c     = out_c_q;
    assign dly_act   = dly_act_q;
    assign dly_pend  = (w_target != dly_act_q);
    assign dly_clamp = clamp_q;
    assign err_done  = w_corrupt;
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ptp_chan_delay_line.sv
`default_nettype none
// tb_ptp_chan_delay_line: randomized scoreboard bench for the channel delay line.
module tb_ptp_chan_delay_line;

    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [7:0]  IDLE_C = 8'hFF;
    localparam logic [63:0] MASK   = 64'h1;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_d;
    logic [7:0]  in_c;
    logic [63:0] out_d;
    logic [7:0]  out_c;
    logic [6:0]  dly_cfg;
    logic [5:0]  dly_act;
    logic        dly_pend;
    logic        dly_clamp;
    logic        err_inj;
    logic        err_done;
    logic [31:0] frame_cnt;

    ptp_chan_delay_line dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_d      (in_d),
        .in_c      (in_c),
        .out_d     (out_d),
        .out_c     (out_c),
        .dly_cfg   (dly_cfg),
        .dly_act   (dly_act),
        .dly_pend  (dly_pend),
        .dly_clamp (dly_clamp),
        .err_inj   (err_inj),
        .err_done  (err_done),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [71:0] w;
        int          cyc;
        int          dly;
        bit          sof;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_dly;
    bit   m_arm;
    bit   m_clamp;
    bit   m_prev_idle;
    int   exp_frames;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Output monitor: every non-idle word must be the oldest outstanding one, at its latency.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && ({out_d, out_c} != {IDLE_D, IDLE_C})) begin
                if (q.size() == 0) begin
                    check("unexpected_word", {out_d, out_c}, {IDLE_D, IDLE_C});
                end else begin
                    e = q.pop_front();
                    check("out_word", {out_d, out_c}, e.w);
                    check("latency", cyc - e.cyc, e.dly + 1);
                    if (e.sof) exp_frames++;
                    check("frame_cnt", frame_cnt, exp_frames);
                end
            end
        end
    end

    // One input cycle; called at a falling edge, returns at the next falling edge.
    task automatic step(input logic [63:0] d, input logic [7:0] c, input bit inj);
        bit idle;
        bit corrupt;
        int tgt;
        exp_t e;
        in_d    = d;
        in_c    = c;
        err_inj = inj;
        #1;
        idle    = (d == IDLE_D) && (c == IDLE_C);
        tgt     = (dly_cfg > 63) ? 63 : int'(dly_cfg);
        corrupt = (m_arm || inj) && !idle;
        check("dly_act", dly_act, m_dly);
        check("dly_pend", dly_pend, (tgt != m_dly));
        check("dly_clamp", dly_clamp, m_clamp);
        check("err_done", err_done, corrupt);
        m_clamp = m_clamp || (dly_cfg > 63);
        m_arm   = corrupt ? 1'b0 : (m_arm || inj);
        if (!idle) begin
            e.w   = {(corrupt ? (d ^ MASK) : d), c};
            e.cyc = cyc;
            e.dly = m_dly;
            e.sof = m_prev_idle;
            q.push_back(e);
        end else if (q.size() == 0) begin
            m_dly = tgt;
        end
        m_prev_idle = idle;
        @(negedge clk);
        err_inj = 1'b0;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) step(IDLE_D, IDLE_C, 1'b0);
    endtask

    task automatic send_word(input bit inj);
        step({$urandom, $urandom}, 8'($urandom_range(0, 254)), inj);
    endtask

    task automatic send_frame(input int len);
        for (int i = 0; i < len; i++) send_word(1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            send_idle(1);
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_d    = IDLE_D;
        in_c    = IDLE_C;
        err_inj = 1'b0;
        q.delete();
        m_dly       = 8;
        m_arm       = 1'b0;
        m_clamp     = 1'b0;
        m_prev_idle = 1'b1;
        exp_frames  = 0;
        #1;
        check("rst_out", {out_d, out_c}, {IDLE_D, IDLE_C});
        check("rst_dly_act", dly_act, 8);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_clamp", dly_clamp, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        in_d    = IDLE_D;
        in_c    = IDLE_C;
        err_inj = 1'b0;
        dly_cfg = 7'd8;
        @(negedge clk);
        do_reset();

        // Default delay, one 10-word frame.
        send_idle(3);
        send_frame(10);
        drain();
        check("frame_cnt_first", frame_cnt, 1);

        // Minimum delay.
        dly_cfg = 7'd0;
        send_idle(2);
        for (int f = 0; f < 3; f++) begin
            send_frame(1 + f * 3);
            send_idle(1 + f);
        end
        drain();

        // Maximum delay with a frame longer than the buffer.
        dly_cfg = 7'd63;
        send_idle(2);
        send_frame(80);
        drain();

        // Increase requested mid-frame.
        dly_cfg = 7'd8;
        send_idle(3);
        send_frame(4);
        dly_cfg = 7'd20;
        send_frame(6);
        drain();
        send_idle(2);
        send_frame(6);
        drain();

        // Decrease between frames.
        dly_cfg = 7'd4;
        send_idle(1);
        send_frame(5);
        send_idle(2);
        send_frame(3);
        drain();

        // Error injection armed during idle, second pulse ignored.
        step(IDLE_D, IDLE_C, 1'b1);
        step(IDLE_D, IDLE_C, 1'b1);
        send_idle(2);
        send_frame(5);
        send_idle(2);
        send_frame(3);
        send_word(1'b1);
        send_frame(2);
        drain();

        // Out-of-range request clamps and stays flagged.
        dly_cfg = 7'd100;
        send_idle(3);
        check("clamp_act", dly_act, 63);
        send_frame(4);
        drain();
        dly_cfg = 7'd5;
        send_idle(3);
        check("clamp_sticky", dly_clamp, 1);

        // Randomized traffic with random delay changes and injections.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) == 0) dly_cfg = 7'($urandom_range(0, 70));
            if ($urandom_range(0, 15) == 0) step(IDLE_D, IDLE_C, 1'b1);
            for (int w = 0; w < int'($urandom_range(1, 12)); w++) begin
                send_word($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 30) == 0) dly_cfg = 7'($urandom_range(0, 40));
            end
            send_idle($urandom_range(0, 5));
        end
        drain();
        check("frame_cnt_random", frame_cnt, exp_frames);

        // Reset in the middle of a frame.
        dly_cfg = 7'd12;
        send_idle(3);
        send_frame(7);
        do_reset();
        dly_cfg = 7'd8;
        send_idle(12);
        check("post_rst_frame_cnt", frame_cnt, 0);
        send_frame(6);
        drain();
        check("post_rst_frames", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
